// File: rtl/tick_gen.sv
// tick_gen: programmable clock-enable generator with free-running and counted-burst modes.
// Optional burst logic is compiled in when TICK_GEN_BURST_EN is defined.
module tick_gen #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 100,
  parameter int BURST_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [WIDTH-1:0]   div_in,
  input  logic               div_load,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_start,
  output logic               ce,
  output logic               busy,
  output logic               burst_done
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef TICK_GEN_BURST_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2} state_t;
  localparam logic [BURST_W-1:0] REM_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] REM_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
`else
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

  // A programmed divisor of zero behaves like one.
  function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
    eff_div = (d == CNT_ZERO) ? CNT_ONE : d;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_next_s;
  logic [WIDTH-1:0] div_r, div_r_next_s;
  logic [WIDTH-1:0] div_s, div_s_next_s;
  logic             ce_next_s;
  logic             wrap_s;

  assign wrap_s       = (cnt_r == (eff_div(div_r) - CNT_ONE));
  assign div_s_next_s = div_load ? div_in : div_s;

`ifdef TICK_GEN_BURST_EN
  logic [BURST_W-1:0] rem_r, rem_next_s;
  logic               done_next_s;
`else
  logic unused_burst_s;
  assign unused_burst_s = ^{burst_start, burst_len};
  assign busy           = 1'b0;
  assign burst_done     = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic; burst_start wins over run
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
`ifdef TICK_GEN_BURST_EN
        if (burst_start)  state_s = BURST;
        else if (run)     state_s = RUN;
        else              state_s = IDLE;
`else
        if (run)          state_s = RUN;
        else              state_s = IDLE;
`endif
      end
      RUN: begin
`ifdef TICK_GEN_BURST_EN
        if (burst_start)  state_s = BURST;
        else if (!run)    state_s = IDLE;
        else              state_s = RUN;
`else
        if (!run)         state_s = IDLE;
        else              state_s = RUN;
`endif
      end
`ifdef TICK_GEN_BURST_EN
      BURST: begin
        if ((rem_r == REM_ZERO) || (wrap_s && (rem_r == REM_ONE))) state_s = run ? RUN : IDLE;
        else                                                       state_s = BURST;
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // prescaler, divisor handover and output pulse decode
  always_comb begin
    cnt_next_s   = cnt_r;
    div_r_next_s = div_r;
    ce_next_s    = 1'b0;
`ifdef TICK_GEN_BURST_EN
    rem_next_s   = rem_r;
    done_next_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        cnt_next_s = CNT_ZERO;
        if (div_load) div_r_next_s = div_in;
        else          div_r_next_s = div_r;
`ifdef TICK_GEN_BURST_EN
        if (burst_start) rem_next_s = burst_len;
        else             rem_next_s = rem_r;
`endif
      end
      RUN: begin
`ifdef TICK_GEN_BURST_EN
        if (burst_start) begin
          cnt_next_s = CNT_ZERO;
          rem_next_s = burst_len;
        end else if (!run) begin
          cnt_next_s = CNT_ZERO;
        end else if (wrap_s) begin
          cnt_next_s   = CNT_ZERO;
          ce_next_s    = 1'b1;
          div_r_next_s = div_s;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
`else
        if (!run) begin
          cnt_next_s = CNT_ZERO;
        end else if (wrap_s) begin
          cnt_next_s   = CNT_ZERO;
          ce_next_s    = 1'b1;
          div_r_next_s = div_s;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
`endif
      end
`ifdef TICK_GEN_BURST_EN
      BURST: begin
        if (rem_r == REM_ZERO) begin
          cnt_next_s  = CNT_ZERO;
          done_next_s = 1'b1;
        end else if (wrap_s) begin
          cnt_next_s   = CNT_ZERO;
          ce_next_s    = 1'b1;
          div_r_next_s = div_s;
          rem_next_s   = rem_r - REM_ONE;
          done_next_s  = (rem_r == REM_ONE);
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
`endif
      default: cnt_next_s = CNT_ZERO;
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r      <= CNT_ZERO;
      div_r      <= DIV_RST;
      div_s      <= DIV_RST;
      ce         <= 1'b0;
`ifdef TICK_GEN_BURST_EN
      rem_r      <= REM_ZERO;
      busy       <= 1'b0;
      burst_done <= 1'b0;
`endif
    end else begin
      cnt_r      <= cnt_next_s;
      div_r      <= div_r_next_s;
      div_s      <= div_s_next_s;
      ce         <= ce_next_s;
`ifdef TICK_GEN_BURST_EN
      rem_r      <= rem_next_s;
      busy       <= (state_s == BURST);
      burst_done <= done_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen; expected ce / burst_done edge numbers are
// queued as stimulus is applied and matched against the pulses the DUT produces.
module tb_tick_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] div_in;
  logic        div_load;
  logic [7:0]  burst_len;
  logic        burst_start;
  logic        ce;
  logic        busy;
  logic        burst_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ce_q[$];
  int done_q[$];

  tick_gen #(.WIDTH(16), .DEFAULT_DIV(100), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .run(run), .div_in(div_in), .div_load(div_load),
    .burst_len(burst_len), .burst_start(burst_start),
    .ce(ce), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    check_eq({tag, "_ce_left"}, ce_q.size(), 0);
    check_eq({tag, "_done_left"}, done_q.size(), 0);
    ce_q.delete();
    done_q.delete();
  endtask

  // scoreboard: pop on each expected edge, flag any pulse nobody asked for
  always @(negedge clk) begin
    if (rst) begin
      check_eq("rst_outputs", int'({ce, busy, burst_done}), 0);
    end else begin
      if (ce_q.size() > 0 && ce_q[0] == cyc) begin
        check_eq("ce_pulse", int'(ce), 1);
        ce_q.delete(0);
      end else if (ce) begin
        check_eq("ce_extra", int'(ce), 0);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        check_eq("done_pulse", int'(burst_done), 1);
        done_q.delete(0);
      end else if (burst_done) begin
        check_eq("done_extra", int'(burst_done), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int c;
    rst = 1'b1; run = 1'b0; div_load = 1'b0; div_in = 16'd0;
    burst_start = 1'b0; burst_len = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ce", int'(ce), 0);
    check_eq("idle_busy", int'(busy), 0);

    // reset mid-run, then release with run held high
    run = 1'b1;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = cyc + 1;
    for (int i = 1; i <= 3; i++) ce_q.push_back(k + 100 * i);
    wait_cyc(k + 300);
    run = 1'b0;
    wait_cyc(k + 320);
    drain("reset_first");

    // reload 6 mid-period, then divisor 0
    run = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 100);
    for (int i = 1; i <= 8; i++) ce_q.push_back(k + 100 + 6 * i);
    for (int i = 0; i <= 10; i++) ce_q.push_back(k + 154 + i);
    wait_cyc(k + 30);
    div_in = 16'd6; div_load = 1'b1;
    wait_cyc(k + 31);
    div_load = 1'b0;
    wait_cyc(k + 150);
    div_in = 16'd0; div_load = 1'b1;
    wait_cyc(k + 151);
    div_load = 1'b0;
    wait_cyc(k + 164);
    run = 1'b0;
    wait_cyc(k + 175);
    drain("reload");

    // load in IDLE is immediate; stopping mid-period clears the prescaler
    c = cyc;
    div_in = 16'd5; div_load = 1'b1;
    wait_cyc(c + 1);
    div_load = 1'b0;
    wait_cyc(c + 3);
    run = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 5);
    ce_q.push_back(k + 10);
    wait_cyc(k + 12);
    run = 1'b0;
    wait_cyc(k + 20);
    run = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 5);
    ce_q.push_back(k + 10);
    wait_cyc(k + 10);
    run = 1'b0;
    wait_cyc(k + 25);
    drain("stop_restart");

`ifdef TICK_GEN_BURST_EN
    c = cyc;
    div_in = 16'd4; div_load = 1'b1;
    wait_cyc(c + 1);
    div_load = 1'b0;

    // burst of 3 from IDLE, with a second start ignored mid-burst
    burst_len = 8'd3; burst_start = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 4); ce_q.push_back(k + 8); ce_q.push_back(k + 12);
    done_q.push_back(k + 12);
    wait_cyc(k);
    burst_start = 1'b0;
    check_eq("burst_busy_entry", int'(busy), 1);
    wait_cyc(k + 5);
    burst_len = 8'd7; burst_start = 1'b1;
    wait_cyc(k + 6);
    burst_start = 1'b0;
    wait_cyc(k + 11);
    check_eq("burst_busy_end", int'(busy), 1);
    wait_cyc(k + 13);
    check_eq("burst_busy_after", int'(busy), 0);
    wait_cyc(k + 30);
    drain("burst3");

    // zero-length burst
    burst_len = 8'd0; burst_start = 1'b1;
    k = cyc + 1;
    done_q.push_back(k + 1);
    wait_cyc(k);
    burst_start = 1'b0;
    check_eq("burst0_busy", int'(busy), 1);
    wait_cyc(k + 1);
    check_eq("burst0_busy_after", int'(busy), 0);
    wait_cyc(k + 12);
    drain("burst0");

    // burst started from RUN restarts the period, then free-running resumes
    run = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 4); ce_q.push_back(k + 8);
    wait_cyc(k + 10);
    burst_len = 8'd2; burst_start = 1'b1;
    ce_q.push_back(k + 15); ce_q.push_back(k + 19);
    ce_q.push_back(k + 23); ce_q.push_back(k + 27);
    done_q.push_back(k + 19);
    wait_cyc(k + 11);
    burst_start = 1'b0;
    wait_cyc(k + 12);
    check_eq("burst_run_busy", int'(busy), 1);
    wait_cyc(k + 27);
    run = 1'b0;
    wait_cyc(k + 40);
    drain("burst_run");
`else
    // burst controls have no effect in IDLE or RUN
    burst_len = 8'd3; burst_start = 1'b1;
    c = cyc;
    wait_cyc(c + 1);
    burst_start = 1'b0;
    wait_cyc(c + 2);
    check_eq("noburst_busy", int'(busy), 0);
    wait_cyc(c + 20);
    check_eq("noburst_done", int'(burst_done), 0);
    run = 1'b1;
    k = cyc + 1;
    ce_q.push_back(k + 5); ce_q.push_back(k + 10); ce_q.push_back(k + 15);
    wait_cyc(k + 7);
    burst_start = 1'b1;
    wait_cyc(k + 8);
    burst_start = 1'b0;
    wait_cyc(k + 9);
    check_eq("noburst_run_busy", int'(busy), 0);
    wait_cyc(k + 15);
    run = 1'b0;
    wait_cyc(k + 30);
    drain("noburst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Programmable clock-enable generator that sits directly upstream of the mod-N counters. It divides `clk` by a run-time divisor and drives their `ce` input with single-cycle pulses. It runs either free-running or in a counted burst of exactly `burst_len` pulses, so a downstream counter advances a known number of steps.

## Interface
- `WIDTH`, 16: width of the divisor and prescaler counter.
- `DEFAULT_DIV`, 100: divisor value after reset; must be ≥1 and < 2^WIDTH.
- `BURST_W`, 8: width of the burst length and remaining-count registers.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; free-running pulse generation while high.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  single-cycle strobe that captures `div_in` into the shadow divisor.
- `burst_len`  in  BURST_W  number of pulses in a burst; sampled on `burst_start`.
- `burst_start`  in  1  single-cycle strobe that starts a burst.
- `ce`  out  1  registered output pulse, one cycle wide; connects to the counter's `ce`.
- `busy`  out  1  high while in the BURST state.
- `burst_done`  out  1  one-cycle pulse when a burst completes.

## Operation
- **Registers:** `state` ∈ {IDLE, RUN, BURST}, prescaler `cnt`, active divisor `div_r`, shadow divisor `div_s`, remaining count `rem`.
- **Reset values:** `state`=IDLE, `cnt`=0, `div_r`=`div_s`=DEFAULT_DIV, `rem`=0, `ce`=0, `busy`=0, `burst_done`=0. Reset is effective mid-operation; a burst in progress is aborted with no `burst_done`.
- **Divisor 0:** a divisor of 0 is treated as 1 (`ce` every cycle).
- **div_load:** writes `div_s`.
  - In IDLE, `div_r` is also updated on the same edge.
  - In RUN or BURST, `div_r` ← `div_s` only at a period wrap (`cnt`==`div_r`-1), so a period is never truncated.
- **Prescaler:** in RUN and BURST, `cnt` increments each cycle. When `cnt`==`div_r`-1, `cnt` wraps to 0 and `ce` is set to 1 for the next cycle. In IDLE, `cnt` is held at 0 and `ce`=0.
- **IDLE transitions:**
  - `burst_start`=1 → BURST, with `rem`←`burst_len`. `burst_start` has priority over `run`.
  - Otherwise `run`=1 → RUN.
- **RUN transitions:**
  - `run`=0 → IDLE; `cnt` is cleared and any pending period is discarded.
  - `burst_start`=1 → BURST, with `cnt`←0 and `rem`←`burst_len`.
- **BURST behaviour:**
  - `rem` decrements on every wrap.
  - On the wrap where `rem`==1, `burst_done` is registered high together with that final `ce`. The state then goes to RUN if `run`=1, else IDLE, with `cnt`←0.
  - `burst_start` is ignored in BURST.
  - `run` changes do not abort a burst.
- **burst_len=0:** enters BURST for one cycle and emits no `ce`. `burst_done` pulses on the following edge, then the state returns to IDLE or RUN.
- **busy:** equals (`state`==BURST), registered.

## Timing
- **Pulse latency:** with `run` sampled high at edge k in IDLE, the first `ce` rises at edge k+`div_r` and recurs every `div_r` cycles. With `div_r`=1, `ce` is high continuously from edge k+1.
- **Stop:** `ce` deasserts on the edge after `run` is sampled low. A pulse already registered still completes its single cycle.
- **Burst duration:** a burst of L≥1 started at edge k produces `ce` at edges k+d, k+2d, …, k+L·d, where d=`div_r`. `burst_done` is high in the same cycle as the L-th `ce`.
- **Divisor change:** a `div_load` during RUN takes effect from the period starting after the next wrap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`TICK_GEN_BURST_EN` defined:** BURST state, `rem` register and burst logic are compiled in, as described above.
- **`TICK_GEN_BURST_EN` undefined:** BURST logic is removed.
  - `burst_start` and `burst_len` are ignored.
  - `busy` and `burst_done` are tied to 0.
  - The state machine is IDLE/RUN only.
  - Port list is unchanged.

## Test plan
- **Reset and first pulse:** assert `rst` mid-run, then release with `run`=1 and DEFAULT_DIV=100. Outputs are 0 during reset; the first `ce` is at 100 cycles, then every 100 cycles; each `ce` is exactly 1 cycle wide.
- **Divisor reload:** `div_load` with `div_in`=6 while running at 100. The current 100-cycle period completes, then periods are 6 cycles; with a downstream mod-6 counter, `out` wraps 5→0 every 36 cycles.
- **Burst:** `div_r`=4, `burst_len`=3, `burst_start` from IDLE. Exactly 3 `ce` pulses at +4/+8/+12 cycles; `burst_done` coincides with the third; `busy` is high throughout, then the state returns to IDLE.
- **Edge values:**
  - `div_in`=0 gives `ce` every cycle.
  - `burst_len`=0 gives no `ce`, with `burst_done` one cycle after entry.
  - `burst_start` during BURST is ignored (the count stays 3).
- **Stop and interplay:** `run` dropped mid-period results in no further `ce` and `cnt` cleared. `burst_start` in RUN with `run` held high restarts the period, emits L pulses, then free-running resumes.
- **Macro undefined:** `burst_start` pulses produce no state change; `busy` and `burst_done` stay 0; RUN behaviour is identical to the first scenario.
